a8_read_responder: RTL
======================

// Module: a8_read_responder
// PURPOSE
//  Read-side counterpart of the pixl A8 bus write capture. Watches Atari 8-bit bus cycles
//  in the clk200 domain and detects CPU reads of the $D6xx window. Fetches the byte from
//  the internal register file via a req/ack handshake, drives it onto the bus during phi2
//  and pulls a8_extsel_n low to disable the host's internal decode for that cycle.
// PARAMETERS
//  BASE_HI       8'hD6  address page (a8_addr[15:8]) this block answers
//  SETTLE_CYC    4      clk200 cycles after synced phi2 rise before addr/rw_n are sampled
//  FETCH_TMO     32     max clk200 cycles from rd_req to rd_ack before the fetch is abandoned
//  HOLD_CYC      4      clk200 cycles data stays driven after synced phi2 fall
// PORTS
//  clk200        in   1   200 MHz system clock
//  a8_rst_n      in   1   async active-low reset
//  a8_clk        in   1   Atari phi2, async to clk200
//  a8_addr       in   16  Atari address bus
//  a8_rw_n       in   1   1 = read cycle
//  a8_halt_n     in   1   0 = ANTIC owns bus; cycle ignored
//  a8_ref_n      in   1   0 = refresh cycle; cycle ignored
//  a8_data_out   out  8   byte to drive onto a8_data
//  a8_data_oe    out  1   1 = top level enables a8_data tristate driver
//  a8_extsel_n   out  1   0 = this device claims the current read
//  rd_req        out  1   request to register file, level, held until rd_ack
//  rd_addr       out  8   register index = a8_addr[7:0] latched at decode
//  rd_data       in   8   register file data, valid with rd_ack
//  rd_ack        in   1   one-cycle pulse completing the fetch
//  tmo_count     out  8   saturating count of abandoned fetches
// BEHAVIOUR
//  Reset: a8_data_out=8'h00, a8_data_oe=0, a8_extsel_n=1, rd_req=0, rd_addr=0,
//   tmo_count=0, FSM=IDLE, phi2 sync chain=0. Assertion async; release is
//   synchronised internally with a 2-flop chain.
//  a8_clk passes a 2-flop synchroniser; rise/fall are detected on the synced copy
//   (edge seen 2-3 cycles after the pin edge).
//  IDLE:   on synced rise -> SETTLE, counter=0.
//  SETTLE: when counter==SETTLE_CYC-1, sample bus.
//          Claim only if rw_n=1 && halt_n=1 && ref_n=1 && addr[15:8]==BASE_HI.
//          Claim: latch rd_addr, rd_req=1, a8_extsel_n=0, go to FETCH.
//          No claim: go to WAIT.
//  FETCH:  on rd_ack, latch rd_data into a8_data_out, rd_req=0, a8_data_oe=1,
//           go to DRIVE.
//          After FETCH_TMO cycles with no ack: a8_data_out=8'hFF, a8_data_oe=1,
//           rd_req=0, tmo_count+1 (saturates at 255), go to DRIVE.
//          Synced fall while in FETCH: rd_req=0, oe stays 0, tmo_count+1, go to HOLD.
//          rd_ack arriving in that same cycle is ignored.
//  DRIVE:  on synced fall -> HOLD, counter=0.
//  HOLD:   after HOLD_CYC cycles: a8_data_oe=0, a8_extsel_n=1, go to IDLE.
//  WAIT:   unclaimed cycle; return to IDLE on synced fall.
//  A synced rise seen in any state other than IDLE, including an immediate re-rise
//   after HOLD, waits until IDLE. Cycles are never double-claimed.
//  rd_ack outside FETCH is ignored. a8_extsel_n is low for exactly one claimed phi2 cycle.
//  Writes to $D6xx are never claimed here; the write-capture block owns them.
//  Address/rw_n are sampled once in SETTLE; later changes within the cycle are ignored.
// STRUCTURE
//  Shared package a8_bus_pkg: FSM state enum (IDLE, SETTLE, FETCH, DRIVE, HOLD, WAIT),
//   page constant D6_PAGE=8'hD6, default bus byte BUS_IDLE=8'hFF.
//  One sub-module: a8_edge_sync (2-flop synchroniser + rise/fall pulses).
//   Shared with the write-capture path.
//  One shared down-counter serves SETTLE/FETCH/HOLD timing; 8-bit saturating tmo counter.
// TESTING
//  Bench runs clk200 with 5 ns period and a8_clk with 576 ns period, async phase offsets.
//  1. Read $D612, rd_ack 3 cycles after rd_req, rd_data=8'hA5:
//      -> extsel_n low and oe=1 with data 8'hA5 before phi2 fall;
//         both release HOLD_CYC cycles after synced fall.
//  2. Read $0600 and write $D600 (data 8'h90):
//      -> rd_req, oe and extsel_n never assert.
//  3. Read $D601 with rd_ack withheld:
//      -> after 32 cycles data_out=8'hFF, oe=1; tmo_count 0->1.
//  4. Read $D601 with a8_halt_n=0, then with a8_ref_n=0:
//      -> no claim either time.
//  5. Pull a8_rst_n low while in DRIVE:
//      -> oe=0, extsel_n=1, rd_req=0 immediately with no clock edge;
//         next $D6xx read after release is served normally.
//  6. Back-to-back reads of $D610/$D611 returning 8'h11/8'h22:
//      -> each cycle drives its own byte; exactly one rd_req per cycle;
//         extsel_n high between them.

Source files
------------

// File: rtl/a8_bus_pkg.sv
// Shared definitions for the Atari 8-bit bus capture/response blocks.
`timescale 1ns/1ps
package a8_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_FETCH  = 3'd2,
    ST_DRIVE  = 3'd3,
    ST_HOLD   = 3'd4,
    ST_WAIT   = 3'd5
  } a8_state_e;

  localparam logic [7:0] D6_PAGE  = 8'hD6;
  localparam logic [7:0] BUS_IDLE = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    if (value == 8'hFF) begin
      sat_inc8 = value;
    end else begin
      sat_inc8 = value + 8'd1;
    end
  endfunction

endpackage

// File: rtl/a8_edge_sync.sv
// Two-flop synchroniser for an asynchronous level, with single-cycle rise/fall
// pulses taken from the synchronised copy.
`timescale 1ns/1ps
module a8_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  // pipe_r[1:0] is the synchroniser, pipe_r[2] the delayed copy for edge detection
  logic [2:0] pipe_r;

  // synchroniser and edge-history shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_r <= 3'b000;
    end else begin
      pipe_r <= {pipe_r[1:0], din};
    end
  end

  assign rise = pipe_r[1] & ~pipe_r[2];
  assign fall = ~pipe_r[1] & pipe_r[2];

endmodule

// File: rtl/a8_read_responder.sv
// Claims CPU reads of one Atari page, fetches the byte from the register file
// and presents it on the bus for the phi2 high phase plus a short hold.
`timescale 1ns/1ps
module a8_read_responder
  import a8_bus_pkg::*;
#(
  parameter logic [7:0] BASE_HI    = D6_PAGE,
  parameter int         SETTLE_CYC = 4,
  parameter int         FETCH_TMO  = 32,
  parameter int         HOLD_CYC   = 4
) (
  input  logic        clk200,
  input  logic        a8_rst_n,
  input  logic        a8_clk,
  input  logic [15:0] a8_addr,
  input  logic        a8_rw_n,
  input  logic        a8_halt_n,
  input  logic        a8_ref_n,
  output logic [7:0]  a8_data_out,
  output logic        a8_data_oe,
  output logic        a8_extsel_n,
  output logic        rd_req,
  output logic [7:0]  rd_addr,
  input  logic [7:0]  rd_data,
  input  logic        rd_ack,
  output logic [7:0]  tmo_count
);

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC) - 8'd1;
  localparam logic [7:0] FETCH_LD  = 8'(FETCH_TMO) - 8'd1;
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC) - 8'd1;

  logic [1:0] rst_sync_r;
  logic       rst_n_s;
  logic       rise_s;
  logic       fall_s;
  logic       claim_s;

  a8_state_e  state_r, state_nxt;
  logic [7:0] cnt_r, cnt_nxt;
  logic       pend_r, pend_nxt;
  logic [7:0] data_out_nxt;
  logic       oe_nxt;
  logic       extsel_nxt;
  logic       req_nxt;
  logic [7:0] addr_nxt;
  logic [7:0] tmo_nxt;

  // reset asserts immediately, releases two clk200 edges later
  always_ff @(posedge clk200 or negedge a8_rst_n) begin
    if (!a8_rst_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  a8_edge_sync u_phi2_sync (
    .clk   (clk200),
    .rst_n (rst_n_s),
    .din   (a8_clk),
    .rise  (rise_s),
    .fall  (fall_s)
  );

  assign claim_s = a8_rw_n && a8_halt_n && a8_ref_n && (a8_addr[15:8] == BASE_HI);

  // state, shared timer and all registered outputs
  always_ff @(posedge clk200 or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 8'd0;
      pend_r      <= 1'b0;
      a8_data_out <= 8'h00;
      a8_data_oe  <= 1'b0;
      a8_extsel_n <= 1'b1;
      rd_req      <= 1'b0;
      rd_addr     <= 8'h00;
      tmo_count   <= 8'h00;
    end else begin
      state_r     <= state_nxt;
      cnt_r       <= cnt_nxt;
      pend_r      <= pend_nxt;
      a8_data_out <= data_out_nxt;
      a8_data_oe  <= oe_nxt;
      a8_extsel_n <= extsel_nxt;
      rd_req      <= req_nxt;
      rd_addr     <= addr_nxt;
      tmo_count   <= tmo_nxt;
    end
  end

  // next-state and output decisions; a rise outside IDLE is remembered until IDLE
  always_comb begin
    state_nxt    = state_r;
    cnt_nxt      = cnt_r;
    data_out_nxt = a8_data_out;
    oe_nxt       = a8_data_oe;
    extsel_nxt   = a8_extsel_n;
    req_nxt      = rd_req;
    addr_nxt     = rd_addr;
    tmo_nxt      = tmo_count;

    if (fall_s) begin
      pend_nxt = 1'b0;
    end else if (rise_s && (state_r != ST_IDLE)) begin
      pend_nxt = 1'b1;
    end else begin
      pend_nxt = pend_r;
    end

    case (state_r)
      ST_IDLE: begin
        pend_nxt = 1'b0;
        if (rise_s || (pend_r && !fall_s)) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = SETTLE_LD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (fall_s) begin
          state_nxt = ST_IDLE;
        end else if (cnt_r == 8'd0) begin
          if (claim_s) begin
            addr_nxt   = a8_addr[7:0];
            req_nxt    = 1'b1;
            extsel_nxt = 1'b0;
            cnt_nxt    = FETCH_LD;
            state_nxt  = ST_FETCH;
          end else begin
            state_nxt = ST_WAIT;
          end
        end else begin
          cnt_nxt = cnt_r - 8'd1;
        end
      end
      ST_FETCH: begin
        if (fall_s) begin
          req_nxt   = 1'b0;
          tmo_nxt   = sat_inc8(tmo_count);
          cnt_nxt   = HOLD_LD;
          state_nxt = ST_HOLD;
        end else if (rd_ack) begin
          data_out_nxt = rd_data;
          req_nxt      = 1'b0;
          oe_nxt       = 1'b1;
          state_nxt    = ST_DRIVE;
        end else if (cnt_r == 8'd0) begin
          data_out_nxt = BUS_IDLE;
          req_nxt      = 1'b0;
          oe_nxt       = 1'b1;
          tmo_nxt      = sat_inc8(tmo_count);
          state_nxt    = ST_DRIVE;
        end else begin
          cnt_nxt = cnt_r - 8'd1;
        end
      end
      ST_DRIVE: begin
        if (fall_s) begin
          cnt_nxt   = HOLD_LD;
          state_nxt = ST_HOLD;
        end else begin
          state_nxt = ST_DRIVE;
        end
      end
      ST_HOLD: begin
        if (cnt_r == 8'd0) begin
          oe_nxt     = 1'b0;
          extsel_nxt = 1'b1;
          state_nxt  = ST_IDLE;
        end else begin
          cnt_nxt = cnt_r - 8'd1;
        end
      end
      ST_WAIT: begin
        if (fall_s) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      default: begin
        state_nxt  = ST_IDLE;
        oe_nxt     = 1'b0;
        extsel_nxt = 1'b1;
        req_nxt    = 1'b0;
      end
    endcase
  end

endmodule
